// File: rtl/stopwatch_pkg.sv
// Shared state encoding and elaboration-time helpers for the stopwatch control block.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_e;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  function automatic int calc_presc_w(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

  function automatic int calc_db(input int clk_hz, input int debounce_ms);
    return (clk_hz / 1000) * debounce_ms;
  endfunction

endpackage

// File: rtl/key_conditioner.sv
// Raw active-low key -> one-cycle press pulse: 3-flop synchroniser, falling-edge detect.
// Optional debounce filter after s1 when STOPWATCH_CTRL_DEBOUNCE_EN is defined.
module key_conditioner
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  if (CLK_HZ <= 0 || DEBOUNCE_MS < 0) begin : g_param_check
    $error("key_conditioner: CLK_HZ must be positive and DEBOUNCE_MS non-negative");
  end

  logic s0_q, s1_q, s2_q;
  logic lvl;

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
  localparam int DB = calc_db(CLK_HZ, DEBOUNCE_MS);
  localparam int CW = (DB < 1) ? 1 : $clog2(DB + 1);

  logic          filt_q;
  logic [CW-1:0] cnt_q;

  // Filtered level follows s1 only after DB consecutive disagreeing samples.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else if (s1_q != filt_q) begin
      if (cnt_q >= CW'(DB - 1)) begin
        filt_q <= s1_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = s1_q;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s0_q <= 1'b1;
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s0_q <= key_n;
      s1_q <= s0_q;
      s2_q <= lvl;
    end
  end

  assign press = s2_q & ~lvl;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap sequencer with tick prescaler and clear/freeze controls.
// Optional key debounce enabled by defining STOPWATCH_CTRL_DEBOUNCE_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int TICK_HZ     = 100,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_start_n,
  input  logic       key_lap_n,
  input  logic       key_clear_n,
  input  logic       overflow,
  output logic       tick,
  output logic       count_clr,
  output logic       display_hold,
  output logic       running,
  output logic [1:0] state
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int PW  = calc_presc_w(DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  if (DIV < 2 || DIV * TICK_HZ != CLK_HZ) begin : g_div_check
    $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be an integer >= 2");
  end

  logic start_p, lap_p, clear_p;

  key_conditioner #(.CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DEBOUNCE_MS)) u_key_start (
    .CLOCK_50(CLOCK_50), .reset(reset), .key_n(key_start_n), .press(start_p));
  key_conditioner #(.CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DEBOUNCE_MS)) u_key_lap (
    .CLOCK_50(CLOCK_50), .reset(reset), .key_n(key_lap_n), .press(lap_p));
  key_conditioner #(.CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DEBOUNCE_MS)) u_key_clear (
    .CLOCK_50(CLOCK_50), .reset(reset), .key_n(key_clear_n), .press(clear_p));

  sw_state_e     state_q, state_d;
  logic          hold_q, hold_d;
  logic          run_q, run_d;
  logic          clr_q, clr_d;
  logic [PW-1:0] presc_q, presc_d;

  // Priority inside each state: overflow > clear > start > lap; losers are dropped.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    clr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_p)      clr_d   = 1'b1;
        else if (start_p) state_d = RUN;
      end
      RUN: begin
        if (overflow || start_p) begin
          state_d = PAUSE;
          hold_d  = 1'b0;
        end else if (lap_p) begin
          state_d = LAP;
          hold_d  = 1'b1;
        end
      end
      LAP: begin
        if (overflow || start_p) begin
          state_d = PAUSE;
          hold_d  = 1'b0;
        end else if (lap_p) begin
          state_d = RUN;
          hold_d  = 1'b0;
        end
      end
      PAUSE: begin
        if (clear_p) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end else if (start_p) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    run_d = (state_d == RUN) || (state_d == LAP);
  end

  // Prescaler holds in PAUSE so partial tick time survives a pause.
  always_comb begin
    presc_d = presc_q;
    if (state_q == IDLE || clr_d) begin
      presc_d = '0;
    end else if (run_q) begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= 1'b0;
      run_q   <= 1'b0;
      clr_q   <= 1'b0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      run_q   <= run_d;
      clr_q   <= clr_d;
      presc_q <= presc_d;
    end
  end

  assign tick         = run_q & (presc_q == PRESC_MAX);
  assign count_clr    = clr_q;
  assign display_hold = hold_q;
  assign running      = run_q;
  assign state        = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl (DIV=10, DB=2): expected output events queued by cycle stamp.
module tb_stopwatch_ctrl;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_LAP   = 2'd3;
  localparam logic [2:0] K_START = 3'b001;
  localparam logic [2:0] K_LAP   = 3'b010;
  localparam logic [2:0] K_CLEAR = 3'b100;
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] keys_n = 3'b111;
  logic       overflow = 1'b0;
  logic       tick, count_clr, display_hold, running;
  logic [1:0] state;

  stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .DEBOUNCE_MS(2)) dut (
    .CLOCK_50(clk), .reset(reset),
    .key_start_n(keys_n[0]), .key_lap_n(keys_n[1]), .key_clear_n(keys_n[2]),
    .overflow(overflow), .tick(tick), .count_clr(count_clr),
    .display_hold(display_hold), .running(running), .state(state));

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: {stamp[15:0], state[1:0], hold, running, count_clr, tick}
  logic [21:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;
  logic [3:0]  prev_s = 4'd0;
  logic [5:0]  obs;
  logic [21:0] got, exp_e;

  function automatic logic [21:0] ev(input int stamp, input logic [1:0] st, input logic h,
                                     input logic r, input logic c, input logic t);
    return {stamp[15:0], st, h, r, c, t};
  endfunction

  task automatic expect_ev(input logic [21:0] e);
    int i = 0;
    while (i < exp_q.size() && exp_q[i][21:6] <= e[21:6]) i++;
    exp_q.insert(i, e);
  endtask

  task automatic expect_ticks(input int first, input int n, input logic [1:0] st, input logic h);
    for (int k = 0; k < n; k++) expect_ev(ev(first + 10 * k, st, h, 1'b1, 1'b0, 1'b1));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      obs = {state, display_hold, running, count_clr, tick};
      if (tick || count_clr || obs[5:2] != prev_s) begin
        got = {cyc[15:0], obs};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event got stamp=%0d st=%0d hold=%b run=%b clr=%b tick=%b (none expected)",
                   got[21:6], got[5:4], got[3], got[2], got[1], got[0]);
        end else begin
          exp_e = exp_q.pop_front();
          if (got !== exp_e) begin
            failures++;
            $display("FAIL event got stamp=%0d st=%0d hold=%b run=%b clr=%b tick=%b exp stamp=%0d st=%0d hold=%b run=%b clr=%b tick=%b",
                     got[21:6], got[5:4], got[3], got[2], got[1], got[0],
                     exp_e[21:6], exp_e[5:4], exp_e[3], exp_e[2], exp_e[1], exp_e[0]);
          end
        end
      end
      prev_s <= obs[5:2];
    end
  end

  // driver tasks
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp_v);
    end
  endtask

  task automatic wait_to(input int n);
    if (cyc > n) begin
      checks++;
      failures++;
      $display("FAIL schedule now=%0d target=%0d", cyc, n);
    end
    while (cyc < n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] mask, input int eff, input int hold, input bit ovf);
    wait_to(eff - LAT);
    keys_n = keys_n & ~mask;
    for (int k = 0; k < hold; k++) begin
      overflow = ovf && (cyc == eff - 1);
      @(negedge clk);
    end
    keys_n   = keys_n | mask;
    overflow = 1'b0;
  endtask

  int e1, p1, e2, e3, p3, x, e4, e5, e6;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_state", {6'd0, state}, 8'd0);
    chk("rst_tick", {7'd0, tick}, 8'd0);
    chk("rst_count_clr", {7'd0, count_clr}, 8'd0);
    chk("rst_display_hold", {7'd0, display_hold}, 8'd0);
    chk("rst_running", {7'd0, running}, 8'd0);
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // start held 50 cycles: one event, ticks every 10 from RUN entry
    e1 = cyc + 10;
    expect_ev(ev(e1, S_RUN, 1'b0, 1'b1, 1'b0, 1'b0));
    expect_ticks(e1 + 9, 5, S_RUN, 1'b0);
    press(K_START, e1, 50, 1'b0);
    p1 = e1 + 55;
    expect_ev(ev(p1, S_PAUSE, 1'b0, 1'b0, 1'b0, 1'b0));
    press(K_START, p1, 4, 1'b0);

    // resume after 40 paused cycles: prescaler kept at 5
    e2 = p1 + 40;
    expect_ev(ev(e2, S_RUN, 1'b0, 1'b1, 1'b0, 1'b0));
    expect_ticks(e2 + 4, 2, S_RUN, 1'b0);
    expect_ticks(e2 + 24, 2, S_LAP, 1'b1);
    expect_ticks(e2 + 44, 1, S_RUN, 1'b0);
    expect_ticks(e2 + 54, 1, S_LAP, 1'b1);
    press(K_START, e2, 4, 1'b0);
    expect_ev(ev(e2 + 20, S_LAP, 1'b1, 1'b1, 1'b0, 1'b0));
    press(K_LAP, e2 + 20, 4, 1'b0);
    expect_ev(ev(e2 + 40, S_RUN, 1'b0, 1'b1, 1'b0, 1'b0));
    press(K_LAP, e2 + 40, 4, 1'b0);
    expect_ev(ev(e2 + 50, S_LAP, 1'b1, 1'b1, 1'b0, 1'b0));
    press(K_LAP, e2 + 50, 4, 1'b0);
    expect_ev(ev(e2 + 60, S_PAUSE, 1'b0, 1'b0, 1'b0, 1'b0));
    press(K_START, e2 + 60, 4, 1'b0);

    // clear ignored in RUN, honoured in PAUSE; prescaler restarts from 0
    e3 = e2 + 80;
    expect_ev(ev(e3, S_RUN, 1'b0, 1'b1, 1'b0, 1'b0));
    expect_ticks(e3 + 4, 2, S_RUN, 1'b0);
    press(K_START, e3, 4, 1'b0);
    press(K_CLEAR, e3 + 10, 4, 1'b0);
    p3 = e3 + 20;
    expect_ev(ev(p3, S_PAUSE, 1'b0, 1'b0, 1'b0, 1'b0));
    press(K_START, p3, 4, 1'b0);
    x = p3 + 10;
    expect_ev(ev(x, S_IDLE, 1'b0, 1'b0, 1'b1, 1'b0));
    press(K_CLEAR, x, 4, 1'b0);
    e4 = x + 10;
    expect_ev(ev(e4, S_RUN, 1'b0, 1'b1, 1'b0, 1'b0));
    expect_ticks(e4 + 9, 1, S_RUN, 1'b0);
    press(K_START, e4, 4, 1'b0);

    // overflow beats a same-cycle lap; overflow in PAUSE ignored
    expect_ev(ev(e4 + 15, S_PAUSE, 1'b0, 1'b0, 1'b0, 1'b0));
    press(K_LAP, e4 + 15, 6, 1'b1);
    wait_to(e4 + 20);
    overflow = 1'b1;
    @(negedge clk);
    overflow = 1'b0;

    // clear beats start in PAUSE; clear in IDLE pulses; lap in IDLE ignored
    expect_ev(ev(e4 + 30, S_IDLE, 1'b0, 1'b0, 1'b1, 1'b0));
    press(K_CLEAR | K_START, e4 + 30, 4, 1'b0);
    expect_ev(ev(e4 + 40, S_IDLE, 1'b0, 1'b0, 1'b1, 1'b0));
    press(K_CLEAR, e4 + 40, 4, 1'b0);
    press(K_LAP, e4 + 50, 4, 1'b0);

    // reset while tick is high: everything back to 0 on the next edge
    e5 = e4 + 60;
    expect_ev(ev(e5, S_RUN, 1'b0, 1'b1, 1'b0, 1'b0));
    expect_ticks(e5 + 9, 2, S_RUN, 1'b0);
    expect_ev(ev(e5 + 20, S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0));
    press(K_START, e5, 4, 1'b0);
    wait_to(e5 + 19);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
    // one-cycle glitch filtered; bouncy release gives no second event
    wait_to(e5 + 30);
    keys_n[0] = 1'b0;
    @(negedge clk);
    keys_n[0] = 1'b1;
    e6 = e5 + 50;
    expect_ev(ev(e6, S_RUN, 1'b0, 1'b1, 1'b0, 1'b0));
    expect_ticks(e6 + 9, 1, S_RUN, 1'b0);
    expect_ev(ev(e6 + 13, S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0));
    wait_to(e6 - LAT);
    keys_n[0] = 1'b0;
    repeat (6) @(negedge clk);
    keys_n[0] = 1'b1;
    @(negedge clk);
    keys_n[0] = 1'b0;
    @(negedge clk);
    keys_n[0] = 1'b1;
    wait_to(e6 + 12);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
`endif

    repeat (30) @(negedge clk);
    mon_en = 1'b0;
    while (exp_q.size() != 0) begin
      exp_e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_event exp stamp=%0d st=%0d hold=%b run=%b clr=%b tick=%b",
               exp_e[21:6], exp_e[5:4], exp_e[3], exp_e[2], exp_e[1], exp_e[0]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
